// File: rtl/iob_native_rr_arbiter_pkg.sv
// Purpose : shared types for the IOb-native round-robin arbiter.
// Latency : n/a (types only).
// Backpressure: n/a.
package iob_native_rr_arbiter_pkg;

    // Bus-ownership phases of the arbiter.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } arb_state_t;

    // Bytes per data word, i.e. wstrb width.
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_native_rr_arbiter_prio_enc.sv
// Purpose : round-robin priority encoder, first requester at or above the one-hot pointer wins.
// Latency : combinational.
// Backpressure: none; o_grant is zero when i_req is zero.
// Ports   : i_req (request vector), i_ptr (one-hot start position), o_grant (one-hot winner).
module iob_native_rr_arbiter_prio_enc #(
    parameter int N = 2
) (
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_ptr,
    output logic [N-1:0] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  w_ptr_idx;
    logic [N-1:0]   w_req_rot;
    logic [N-1:0]   w_gnt_rot;
    logic [2*N-1:0] w_gnt_dbl;

    always_comb begin
        w_ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_ptr[i]) begin
                w_ptr_idx = w_ptr_idx | PW'(i);
            end
        end
    end

    // Rotate right so the pointer position lands on bit 0.
    assign w_req_rot = N'({i_req, i_req} >> w_ptr_idx);

    always_comb begin
        w_gnt_rot = '0;
        for (int i = 0; i < N; i++) begin
            if (w_req_rot[i] && (w_gnt_rot == '0)) begin
                w_gnt_rot[i] = 1'b1;
            end
        end
    end

    // Undo the rotation; bits shifted past N wrap back via the upper half.
    assign w_gnt_dbl = {{N{1'b0}}, w_gnt_rot} << w_ptr_idx;
    assign o_grant   = w_gnt_dbl[N-1:0] | w_gnt_dbl[2*N-1:N];

endmodule

// File: rtl/iob_native_rr_arbiter.sv
// Purpose : shares one IOb-native slave among N_MASTERS masters, round-robin, one transaction in flight.
// Latency : 1 cycle request->s_avalid_o; 1 idle cycle between back-to-back transactions.
// Backpressure: s_ready_i low holds the granted lane in REQ; others wait; watchdog frees a silent read.
// Ports   : m_* per-master lanes (packed, master k at k*W), s_* slave side, grant_o debug, timeout_o pulse.
module iob_native_rr_arbiter
    import iob_native_rr_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                            clk_i,
    input  logic                            arst_n_i,
    input  logic [N_MASTERS-1:0]            m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata_i,
    input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb_i,
    output logic [N_MASTERS*DATA_W-1:0]     m_rdata_o,
    output logic [N_MASTERS-1:0]            m_rvalid_o,
    output logic [N_MASTERS-1:0]            m_ready_o,
    output logic                            s_avalid_o,
    output logic [ADDR_W-1:0]               s_addr_o,
    output logic [DATA_W-1:0]               s_wdata_o,
    output logic [DATA_W/8-1:0]             s_wstrb_o,
    input  logic [DATA_W-1:0]               s_rdata_i,
    input  logic                            s_rvalid_i,
    input  logic                            s_ready_i,
    output logic [N_MASTERS-1:0]            grant_o,
    output logic                            timeout_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WDOG_MAX = '1;

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [N_MASTERS-1:0]   r_grant;
    logic [N_MASTERS-1:0]   w_grant_nxt;
    logic [N_MASTERS-1:0]   r_ptr;
    logic [N_MASTERS-1:0]   w_ptr_nxt;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic [N_MASTERS-1:0]   w_arb_grant;
    logic                   w_release;
    logic                   w_timeout;

    logic                   w_sel_avalid;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;
    logic [STRB_W-1:0]      w_sel_wstrb;

    iob_native_rr_arbiter_prio_enc #(
        .N (N_MASTERS)
    ) u_prio_enc (
        .i_req   (m_avalid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant)
    );

    // AND-OR lane mux driven by the registered one-hot grant.
    always_comb begin
        w_sel_avalid = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        w_sel_wstrb  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (r_grant[k]) begin
                w_sel_avalid = w_sel_avalid | m_avalid_i[k];
                w_sel_addr   = w_sel_addr  | m_addr_i[k*ADDR_W +: ADDR_W];
                w_sel_wdata  = w_sel_wdata | m_wdata_i[k*DATA_W +: DATA_W];
                w_sel_wstrb  = w_sel_wstrb | m_wstrb_i[k*STRB_W +: STRB_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|m_avalid_i) begin
                    w_state_nxt = ST_REQ;
                    w_grant_nxt = w_arb_grant;
                end
            end
            ST_REQ: begin
                // A master dropping avalid before ready abandons the request.
                if (!w_sel_avalid) begin
                    w_release = 1'b1;
                end else if (s_ready_i) begin
                    if (w_sel_wstrb == '0) begin
                        w_state_nxt = ST_WAIT_RSP;
                    end else begin
                        w_release = 1'b1;
                    end
                end
            end
            ST_WAIT_RSP: begin
                // A response arriving on the last watchdog cycle still wins.
                if (s_rvalid_i) begin
                    w_release = 1'b1;
                end else if (r_wdog == WDOG_MAX) begin
                    w_timeout = 1'b1;
                    w_release = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
        if (w_release) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_ptr_nxt   = {r_grant[N_MASTERS-2:0], r_grant[N_MASTERS-1]};
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= {{(N_MASTERS-1){1'b0}}, 1'b1};
            r_wdog  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wdog  <= ((r_state == ST_WAIT_RSP) && (w_state_nxt == ST_WAIT_RSP))
                       ? r_wdog + WDOG_ONE : '0;
        end
    end

    assign s_avalid_o = (r_state == ST_REQ) && w_sel_avalid;
    assign s_addr_o   = (r_state == ST_REQ) ? w_sel_addr  : '0;
    assign s_wdata_o  = (r_state == ST_REQ) ? w_sel_wdata : '0;
    assign s_wstrb_o  = (r_state == ST_REQ) ? w_sel_wstrb : '0;

    assign m_ready_o  = ((r_state == ST_REQ) && s_ready_i)       ? r_grant : '0;
    assign m_rvalid_o = ((r_state == ST_WAIT_RSP) && s_rvalid_i) ? r_grant : '0;

    always_comb begin
        m_rdata_o = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if ((r_state == ST_WAIT_RSP) && r_grant[k]) begin
                m_rdata_o[k*DATA_W +: DATA_W] = s_rdata_i;
            end
        end
    end

    assign grant_o   = r_grant;
    assign timeout_o = w_timeout;

endmodule

// File: tb/tb_iob_native_rr_arbiter.sv
// Purpose : directed stimulus for the IOb-native round-robin arbiter with a transaction-level reference.
// Latency : n/a.
// Backpressure: slave ready/rvalid driven directly by the stimulus.
module tb_iob_native_rr_arbiter;

    localparam int TW   = 4;
    localparam int TMAX = (1 << TW) - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  m_avalid;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [63:0] m_rdata;
    logic [1:0]  m_rvalid;
    logic [1:0]  m_ready;
    logic        s_avalid;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic        s_ready;
    logic [1:0]  grant;
    logic        timeout;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    iob_native_rr_arbiter #(
        .N_MASTERS (2),
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT_W (TW)
    ) dut (
        .clk_i      (clk),
        .arst_n_i   (rst_n),
        .m_avalid_i (m_avalid),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_wstrb_i  (m_wstrb),
        .m_rdata_o  (m_rdata),
        .m_rvalid_o (m_rvalid),
        .m_ready_o  (m_ready),
        .s_avalid_o (s_avalid),
        .s_addr_o   (s_addr),
        .s_wdata_o  (s_wdata),
        .s_wstrb_o  (s_wstrb),
        .s_rdata_i  (s_rdata),
        .s_rvalid_i (s_rvalid),
        .s_ready_i  (s_ready),
        .grant_o    (grant),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: who owns the bus, whether it awaits a read response,
    // how long it has waited, and which master has first claim next.
    int md_owner = -1;
    bit md_wait  = 1'b0;
    int md_age   = 0;
    int md_next  = 0;
    int md_pick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_owner <= -1;
            md_wait  <= 1'b0;
            md_age   <= 0;
            md_next  <= 0;
        end else if (md_owner < 0) begin
            md_pick = -1;
            for (int off = 0; off < 2; off++) begin
                if (md_pick < 0 && m_avalid[(md_next + off) % 2]) md_pick = (md_next + off) % 2;
            end
            if (md_pick >= 0) md_owner <= md_pick;
        end else if (!md_wait) begin
            if (!m_avalid[md_owner] || (s_ready && m_wstrb[md_owner*4 +: 4] != 4'h0)) begin
                md_next  <= (md_owner + 1) % 2;
                md_owner <= -1;
            end else if (s_ready) begin
                md_wait <= 1'b1;
                md_age  <= 0;
            end
        end else begin
            if (s_rvalid || md_age == TMAX) begin
                md_next  <= (md_owner + 1) % 2;
                md_owner <= -1;
                md_wait  <= 1'b0;
                md_age   <= 0;
            end else begin
                md_age <= md_age + 1;
            end
        end
    end

    logic [1:0]  e_grant, e_ready, e_rvalid;
    logic        e_savalid, e_timeout;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [63:0] e_rdata;

    always @(negedge clk) begin
        if (chk_en) begin
            e_grant = '0; e_ready = '0; e_rvalid = '0; e_savalid = 1'b0; e_timeout = 1'b0;
            e_addr = '0; e_wdata = '0; e_wstrb = '0; e_rdata = '0;
            if (md_owner >= 0) begin
                e_grant[md_owner] = 1'b1;
                if (!md_wait) begin
                    e_savalid = m_avalid[md_owner];
                    e_addr    = m_addr[md_owner*32 +: 32];
                    e_wdata   = m_wdata[md_owner*32 +: 32];
                    e_wstrb   = m_wstrb[md_owner*4 +: 4];
                    if (s_ready) e_ready[md_owner] = 1'b1;
                end else begin
                    e_rdata[md_owner*32 +: 32] = s_rdata;
                    if (s_rvalid) e_rvalid[md_owner] = 1'b1;
                    e_timeout = !s_rvalid && (md_age == TMAX);
                end
            end
            chk("mdl_grant", grant, e_grant);
            chk("mdl_s_avalid", s_avalid, e_savalid);
            chk("mdl_s_addr", s_addr, e_addr);
            chk("mdl_s_wdata", s_wdata, e_wdata);
            chk("mdl_s_wstrb", s_wstrb, e_wstrb);
            chk("mdl_m_ready", m_ready, e_ready);
            chk("mdl_m_rvalid", m_rvalid, e_rvalid);
            chk("mdl_m_rdata", m_rdata, e_rdata);
            chk("mdl_timeout", timeout, e_timeout);
        end
    end

    initial begin
        #200000;
        $display("FAIL tb_time_limit actual=running expected=finished");
        $fatal(1, "time limit");
    end

    logic [1:0] exp3 [8];
    int         cnt;

    initial begin
        exp3 = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        rst_n = 1'b0; m_avalid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_rdata = '0; s_rvalid = 1'b0; s_ready = 1'b0;
        step(); chk_en = 1'b1; step();
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_avalid", s_avalid, 1'b0);
        step(); rst_n = 1'b1;

        // Single write from m0, slave ready at once.
        m_avalid = 2'b01; m_addr[31:0] = 32'h4; m_wdata[31:0] = 32'hA5; m_wstrb[3:0] = 4'hF; s_ready = 1'b1;
        @(negedge clk);
        chk("t1_arb_latency", s_avalid, 1'b0);
        step(); @(negedge clk);
        chk("t1_s_avalid", s_avalid, 1'b1);
        chk("t1_m_ready", m_ready, 2'b01);
        chk("t1_s_addr", s_addr, 32'h4);
        chk("t1_s_wdata", s_wdata, 32'hA5);
        chk("t1_grant", grant, 2'b01);
        step(); m_avalid = '0; s_ready = 1'b0;
        @(negedge clk);
        chk("t1_release", grant, 2'b00);

        // Read from m1 answered in the third response cycle.
        step(); m_avalid = 2'b10; m_addr[63:32] = 32'h8; m_wstrb[7:4] = 4'h0; s_ready = 1'b1;
        step(); @(negedge clk);
        chk("t2_s_avalid", s_avalid, 1'b1);
        chk("t2_s_addr", s_addr, 32'h8);
        chk("t2_m_ready", m_ready, 2'b10);
        step(); m_avalid = '0; s_ready = 1'b0;
        step();
        step(); s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t2_m_rvalid", m_rvalid, 2'b10);
        chk("t2_rdata_m1", m_rdata[63:32], 32'hDEADBEEF);
        chk("t2_rdata_m0", m_rdata[31:0], 32'h0);
        step(); s_rvalid = 1'b0; s_rdata = '0;

        // Both masters write continuously: grants alternate with an idle gap.
        m_avalid = 2'b11; m_addr = {32'h20, 32'h10}; m_wdata = {32'h2, 32'h1}; m_wstrb = 8'hFF; s_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t3_grant_seq", grant, exp3[i]);
            step();
        end
        m_avalid = '0; s_ready = 1'b0;

        // Read from m0 that never completes; m1 queues a write meanwhile.
        step(); m_avalid = 2'b01; m_addr[31:0] = 32'h30; m_wstrb[3:0] = 4'h0; s_ready = 1'b1;
        step(); @(negedge clk);
        chk("t4_m_ready", m_ready, 2'b01);
        step(); m_avalid = 2'b10; m_addr[63:32] = 32'h40; m_wstrb[7:4] = 4'hF; s_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) break;
            cnt++;
            step();
        end
        chk("t4_wait_cycles", cnt, 15);
        chk("t4_timeout", timeout, 1'b1);
        chk("t4_grant_at_timeout", grant, 2'b01);
        chk("t4_no_rvalid", m_rvalid, 2'b00);
        step(); s_ready = 1'b1;
        @(negedge clk);
        chk("t4_idle_grant", grant, 2'b00);
        step(); @(negedge clk);
        chk("t4_m1_grant", grant, 2'b10);
        chk("t4_m1_ready", m_ready, 2'b10);
        step(); m_avalid = '0; s_ready = 1'b0;

        // Reset during an outstanding read from m1, then a stale response.
        step(); m_avalid = 2'b10; m_addr[63:32] = 32'h50; m_wstrb[7:4] = 4'h0; s_ready = 1'b1;
        step();
        step(); m_avalid = '0; s_ready = 1'b0;
        step(); @(negedge clk);
        chk("t5_grant_in_wait", grant, 2'b10);
        step(); rst_n = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h12345678;
        @(negedge clk);
        chk("t5_rst_grant", grant, 2'b00);
        chk("t5_rst_rvalid", m_rvalid, 2'b00);
        chk("t5_rst_rdata", m_rdata, 64'h0);
        chk("t5_rst_s_avalid", s_avalid, 1'b0);
        chk("t5_rst_timeout", timeout, 1'b0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("t5_late_rvalid", m_rvalid, 2'b00);
        chk("t5_late_rdata", m_rdata, 64'h0);
        chk("t5_post_grant", grant, 2'b00);
        step(); s_rvalid = 1'b0; s_rdata = '0;

        // Slave holds ready low for 5 REQ cycles while m1 also waits.
        m_avalid = 2'b11; m_addr = {32'h70, 32'h60}; m_wdata = {32'h88, 32'h77}; m_wstrb = 8'hF3; s_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_s_addr_hold", s_addr, 32'h60);
            chk("t6_s_wdata_hold", s_wdata, 32'h77);
            chk("t6_s_wstrb_hold", s_wstrb, 4'h3);
            chk("t6_m_ready_low", m_ready, 2'b00);
            chk("t6_grant_hold", grant, 2'b01);
            step();
        end
        s_ready = 1'b1;
        @(negedge clk);
        chk("t6_m0_ready", m_ready, 2'b01);
        step(); m_avalid = 2'b10;
        step(); @(negedge clk);
        chk("t6_m1_grant", grant, 2'b10);
        chk("t6_m1_addr", s_addr, 32'h70);
        step(); m_avalid = '0; s_ready = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
